// File: rtl/xcvr_pattern_gen_mp.sv
// rtl/xcvr_pattern_gen_mp.sv - multi-mode XCVR test-pattern generator (K28.5 preamble, counter/PRBS7/PRBS31/fixed payload)
//
// Ports:
//   clk_i         TX fabric clock, rising edge
//   reset_i       asynchronous active-high reset
//   enable_i      level, 1 = run, 0 = return to IDLE
//   restart_i     1-cycle pulse, re-runs preamble and reseeds the pattern
//   mode_i        00 counter, 01 PRBS7, 10 PRBS31, 11 fixed word
//   fixed_word_i  payload used in mode 11
//   inject_err_i  asynchronous level, each rising edge injects one bit0 error
//   data_out_o    TX data (registered)
//   tx_k_char_o   per-lane K flag, bit0 = byte [7:0] (registered)
//   data_valid_o  1 while data_out_o carries payload (registered)
//   inj_count_o   saturating count of injected errors (registered)

module xcvr_pattern_gen_mp #(
  parameter int G_DATA_WID     = 32,
  parameter int G_ALIGN_CYCLES = 4,
  parameter int G_COMMA_PERIOD = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      restart_i,
  input  logic [1:0]                mode_i,
  input  logic [G_DATA_WID-1:0]     fixed_word_i,
  input  logic                      inject_err_i,
  output logic [G_DATA_WID-1:0]     data_out_o,
  output logic [G_DATA_WID/8-1:0]   tx_k_char_o,
  output logic                      data_valid_o,
  output logic [15:0]               inj_count_o
);

  localparam int L = G_DATA_WID / 8;
  localparam logic [G_DATA_WID-1:0] COMMA_WORD = G_DATA_WID'(8'hBC);
  localparam logic [L-1:0]          K_COMMA    = L'(1);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_DATA, S_COMMA} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              align_cnt_q, align_cnt_d;
  logic [31:0]             dcnt_q, dcnt_d;
  logic [1:0]              mode_q, mode_d;
  logic [G_DATA_WID-1:0]   cnt_q, cnt_d;
  logic [6:0]              p7_q, p7_d;
  logic [30:0]             p31_q, p31_d;
  logic                    sync1_q, sync2_q, sync3_q;
  logic                    pend_q, pend_d;
  logic [G_DATA_WID-1:0]   data_q, data_d;
  logic [L-1:0]            k_q, k_d;
  logic                    valid_q, valid_d;
  logic [15:0]             inj_q, inj_d;

  // Parallel LFSR: G_DATA_WID serial steps unrolled; first generated bit lands in the MSB.
  logic [6:0]              s7;
  logic [30:0]             s31;
  logic [G_DATA_WID-1:0]   w7, w31;

  always_comb begin
    s7  = p7_q;
    s31 = p31_q;
    w7  = '0;
    w31 = '0;
    for (int i = 0; i < G_DATA_WID; i++) begin
      w7[G_DATA_WID-1-i]  = s7[6] ^ s7[5];
      s7                  = {s7[5:0], s7[6] ^ s7[5]};
      w31[G_DATA_WID-1-i] = s31[30] ^ s31[27];
      s31                 = {s31[29:0], s31[30] ^ s31[27]};
    end
  end

  // Synchronised rising edge of the error request.
  logic err_rise;
  assign err_rise = sync2_q & ~sync3_q;

  logic [G_DATA_WID-1:0] payload;
  logic                  err_now;

  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    dcnt_d      = dcnt_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    p7_d        = p7_q;
    p31_d       = p31_q;
    pend_d      = pend_q | err_rise;
    data_d      = COMMA_WORD;
    k_d         = K_COMMA;
    valid_d     = 1'b0;
    inj_d       = inj_q;
    payload     = '0;
    err_now     = pend_q | err_rise;

    if (!enable_i) begin
      state_d = S_IDLE;
    end else if (restart_i) begin
      state_d = S_ALIGN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ALIGN;
        S_ALIGN: if (align_cnt_q == 8'(G_ALIGN_CYCLES)) state_d = S_DATA;
        S_DATA:  if ((G_COMMA_PERIOD > 0) && (dcnt_q == 32'(G_COMMA_PERIOD))) state_d = S_COMMA;
        S_COMMA: state_d = S_DATA;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are a function of the state being entered, so they are registered alongside it.
    case (state_d)
      S_ALIGN: begin
        if (state_q != S_ALIGN || restart_i) begin
          align_cnt_d = 8'd1;
          mode_d      = mode_i;
        end else begin
          align_cnt_d = align_cnt_q + 8'd1;
        end
        cnt_d = G_DATA_WID'(1);
        p7_d  = '1;
        p31_d = '1;
      end
      S_DATA: begin
        dcnt_d = (state_q == S_DATA) ? dcnt_q + 32'd1 : 32'd1;
        case (mode_q)
          2'b00:   payload = cnt_q;
          2'b01:   payload = w7;
          2'b10:   payload = w31;
          default: payload = fixed_word_i;
        endcase
        cnt_d   = cnt_q + G_DATA_WID'(1);
        p7_d    = s7;
        p31_d   = s31;
        data_d  = payload ^ G_DATA_WID'(err_now);
        k_d     = '0;
        valid_d = 1'b1;
        pend_d  = 1'b0;
        if (err_now && inj_q != 16'hFFFF) inj_d = inj_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      align_cnt_q <= '0;
      dcnt_q      <= '0;
      mode_q      <= 2'b00;
      cnt_q       <= G_DATA_WID'(1);
      p7_q        <= '1;
      p31_q       <= '1;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      pend_q      <= 1'b0;
      data_q      <= COMMA_WORD;
      k_q         <= K_COMMA;
      valid_q     <= 1'b0;
      inj_q       <= '0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      dcnt_q      <= dcnt_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      p7_q        <= p7_d;
      p31_q       <= p31_d;
      sync1_q     <= inject_err_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      pend_q      <= pend_d;
      data_q      <= data_d;
      k_q         <= k_d;
      valid_q     <= valid_d;
      inj_q       <= inj_d;
    end
  end

  assign data_out_o   = data_q;
  assign tx_k_char_o  = k_q;
  assign data_valid_o = valid_q;
  assign inj_count_o  = inj_q;

endmodule

// File: tb/tb_xcvr_pattern_gen_mp.sv
// tb/tb_xcvr_pattern_gen_mp.sv - scoreboard bench for xcvr_pattern_gen_mp (32-bit and 8-bit/comma-period instances)

module tb_xcvr_pattern_gen_mp;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        v;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en32 = 0, rs32 = 0, ie32 = 0;
  logic [1:0]  md32 = 0;
  logic [31:0] fw32 = 0;
  logic [31:0] do32;
  logic [3:0]  k32;
  logic        v32;
  logic [15:0] c32;

  logic        en8 = 0, rs8 = 0, ie8 = 0;
  logic [1:0]  md8 = 0;
  logic [7:0]  fw8 = 0;
  logic [7:0]  do8;
  logic [0:0]  k8;
  logic        v8;
  logic [15:0] c8;

  xcvr_pattern_gen_mp #(.G_DATA_WID(32), .G_ALIGN_CYCLES(4), .G_COMMA_PERIOD(0)) u32 (
    .clk_i(clk), .reset_i(rst), .enable_i(en32), .restart_i(rs32), .mode_i(md32),
    .fixed_word_i(fw32), .inject_err_i(ie32), .data_out_o(do32), .tx_k_char_o(k32),
    .data_valid_o(v32), .inj_count_o(c32));

  xcvr_pattern_gen_mp #(.G_DATA_WID(8), .G_ALIGN_CYCLES(2), .G_COMMA_PERIOD(3)) u8 (
    .clk_i(clk), .reset_i(rst), .enable_i(en8), .restart_i(rs8), .mode_i(md8),
    .fixed_word_i(fw8), .inject_err_i(ie8), .data_out_o(do8), .tx_k_char_o(k8),
    .data_valid_o(v8), .inj_count_o(c8));

  exp_t  q32[$], q8[$];
  string n32[$], n8[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitors: one expectation is pushed before each clock edge; it is popped just after it.
  always begin
    exp_t  e;
    string nm;
    @(posedge clk);
    #1;
    if (q32.size() > 0) begin
      e  = q32.pop_front();
      nm = n32.pop_front();
      chk({nm, ".data"},  {32'h0, do32}, e.d);
      chk({nm, ".k"},     {60'h0, k32},  {56'h0, e.k});
      chk({nm, ".valid"}, {63'h0, v32},  {63'h0, e.v});
      chk({nm, ".inj"},   {48'h0, c32},  {48'h0, e.c});
    end
  end

  always begin
    exp_t  e;
    string nm;
    @(posedge clk);
    #1;
    if (q8.size() > 0) begin
      e  = q8.pop_front();
      nm = n8.pop_front();
      chk({nm, ".data"},  {56'h0, do8}, e.d);
      chk({nm, ".k"},     {63'h0, k8},  {56'h0, e.k});
      chk({nm, ".valid"}, {63'h0, v8},  {63'h0, e.v});
      chk({nm, ".inj"},   {48'h0, c8},  {48'h0, e.c});
    end
  end

  function automatic exp_t mk_comma(input logic [15:0] c);
    exp_t e;
    e.d = 64'hBC; e.k = 8'h01; e.v = 1'b0; e.c = c;
    return e;
  endfunction

  function automatic exp_t mk_data(input logic [63:0] d, input logic [15:0] c);
    exp_t e;
    e.d = d; e.k = 8'h00; e.v = 1'b1; e.c = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step32(input string nm, input exp_t e);
    q32.push_back(e);
    n32.push_back(nm);
    tick();
  endtask

  task automatic step8(input string nm, input exp_t e);
    q8.push_back(e);
    n8.push_back(nm);
    tick();
  endtask

  // Golden PRBS7 bit stream: b[n] = b[n-7] ^ b[n-6], history seeded with ones.
  bit pb[$];

  function automatic logic [31:0] prbs7_word();
    logic [31:0] w;
    int          n;
    for (int i = 0; i < 32; i++) begin
      n = pb.size();
      pb.push_back(pb[n-7] ^ pb[n-6]);
      w[31-i] = pb[n-7] ^ pb[n-6];
    end
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m_cnt;
    int         m_dn;

    // Reset values on both instances.
    q32.push_back(mk_comma(0)); n32.push_back("reset32");
    q8.push_back(mk_comma(0));  n8.push_back("reset8");
    tick();

    // 1: counter mode, preamble then 1,2,3...
    rst = 0; en32 = 1; md32 = 2'b00;
    for (int i = 0; i < 4; i++) step32("preamble", mk_comma(0));
    for (int i = 1; i <= 6; i++) step32("counter", mk_data(i, 0));

    // 5: error injection, flipped word three cycles after the request rises.
    ie32 = 1;
    step32("inj_wait1", mk_data(7, 0));
    step32("inj_wait2", mk_data(8, 0));
    step32("inj_flip",  mk_data(9 ^ 1, 1));
    step32("inj_next",  mk_data(10, 1));
    ie32 = 0;
    step32("inj_after", mk_data(11, 1));
    step32("inj_after", mk_data(12, 1));

    // 6: disable wins over restart, then restart mid-DATA reseeds.
    en32 = 0; rs32 = 1;
    step32("en0_over_restart", mk_comma(1));
    rs32 = 0;
    step32("idle", mk_comma(1));
    en32 = 1;
    for (int i = 0; i < 4; i++) step32("preamble2", mk_comma(1));
    for (int i = 1; i <= 3; i++) step32("counter2", mk_data(i, 1));
    rs32 = 1;
    step32("restart_comma", mk_comma(1));
    rs32 = 0;
    for (int i = 0; i < 3; i++) step32("restart_pre", mk_comma(1));
    step32("reseed1", mk_data(1, 1));
    step32("reseed2", mk_data(2, 1));
    rst = 1;
    step32("reset_mid", mk_comma(0));

    // 3: PRBS7 after preamble; a later mode change is ignored.
    md32 = 2'b01;
    rst  = 0;
    for (int i = 0; i < 7; i++) pb.push_back(1'b1);
    for (int i = 0; i < 4; i++) step32("prbs_pre", mk_comma(0));
    for (int i = 0; i < 40; i++) begin
      if (i == 10) md32 = 2'b10;
      step32("prbs7", mk_data({32'h0, prbs7_word()}, 0));
    end

    // Fixed-word mode via restart.
    md32 = 2'b11; fw32 = 32'hDEADBEEF; rs32 = 1;
    step32("fixed_pre", mk_comma(0));
    rs32 = 0;
    for (int i = 0; i < 3; i++) step32("fixed_pre", mk_comma(0));
    for (int i = 0; i < 3; i++) step32("fixed", mk_data(64'hDEADBEEF, 0));
    en32 = 0;

    // 2 and 4: 8-bit counter with comma every 3 data words, through the 0xFF wrap.
    en8 = 1; md8 = 2'b00;
    for (int i = 0; i < 2; i++) step8("u8_pre", mk_comma(0));
    m_cnt = 8'd1;
    m_dn  = 0;
    for (int i = 0; i < 350; i++) begin
      if (m_dn == 3) begin
        step8("u8_comma", mk_comma(0));
        m_dn = 0;
      end else begin
        step8("u8_data", mk_data({56'h0, m_cnt}, 0));
        m_cnt = m_cnt + 8'd1;
        m_dn++;
      end
    end
    en8 = 0;

    tick();
    tick();
    if (q32.size() != 0 || q8.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q32.size(), q8.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
